// File: rtl/cmplx_mul_pkg.sv
// Shared constants and types for the pipelined complex multiplier.
// Saturation is enabled by defining CMPLX_MUL_SAT_EN; the default build wraps.
package cmplx_mul_pkg;

   localparam int unsigned DATA_W_DEF = 18;
   localparam int unsigned OUT_W_DEF  = 18;
   localparam int unsigned SHIFT_DEF  = 17;

   // Full-precision width of a sum of two DATA_W x DATA_W products
   function automatic int unsigned full_w(input int unsigned data_w);
      return 2 * data_w + 1;
   endfunction

   typedef struct packed {
      logic signed [OUT_W_DEF-1:0] i;
      logic signed [OUT_W_DEF-1:0] q;
   } cplx_t;

endpackage

// File: rtl/cmplx_mul_if.sv
// Sample-in / sample-out handshake bus of the complex multiplier.
interface cmplx_mul_if
   import cmplx_mul_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OUT_W  = OUT_W_DEF
) ();

   logic                     s_valid_i;
   logic                     s_ready_o;
   logic                     conj_i;
   logic signed [DATA_W-1:0] data_a_i_i;
   logic signed [DATA_W-1:0] data_a_q_i;
   logic signed [DATA_W-1:0] data_b_i_i;
   logic signed [DATA_W-1:0] data_b_q_i;
   logic                     m_valid_o;
   logic                     m_ready_i;
   logic signed [OUT_W-1:0]  data_i_o;
   logic signed [OUT_W-1:0]  data_q_o;
   logic                     ovf_o;

   modport master (
      output s_valid_i, conj_i, data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i, m_ready_i,
      input  s_ready_o, m_valid_o, data_i_o, data_q_o, ovf_o
   );

   modport slave (
      input  s_valid_i, conj_i, data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i, m_ready_i,
      output s_ready_o, m_valid_o, data_i_o, data_q_o, ovf_o
   );

endinterface

// File: rtl/cmplx_mul_pipe_rnd_sat.sv
// One output component: registers the rounded sum (stage 3), then shifts and
// reduces it to OUT_W combinationally. CMPLX_MUL_SAT_EN selects clamping over wrap.
module cmplx_rnd_sat
   import cmplx_mul_pkg::*;
#(
   parameter int unsigned FW    = full_w(DATA_W_DEF),
   parameter int unsigned OUT_W = OUT_W_DEF,
   parameter int unsigned SHIFT = SHIFT_DEF
) (
   input  logic                    clk_i,
   input  logic                    arst_n_i,
   input  logic                    ce_i,
   input  logic signed [FW-1:0]    sum_i,
   output logic signed [OUT_W-1:0] data_c_o,
   output logic                    ovf_c_o
);

   localparam int unsigned RW = FW + 1;
   localparam int unsigned EW = (OUT_W > RW) ? OUT_W : RW;
   // Half an output LSB; collapses to zero when SHIFT is 0
   localparam logic [RW-1:0] RND_C = (RW'(1) << SHIFT) >> 1;

   logic signed [RW-1:0] rnd_d;
   logic signed [RW-1:0] rnd_q;
   logic signed [EW-1:0] shifted;

   assign rnd_d = RW'(sum_i) + $signed(RND_C);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rnd_q <= '0;
      end else if (ce_i) begin
         rnd_q <= rnd_d;
      end
   end

   assign shifted = EW'(rnd_q) >>> SHIFT;

`ifdef CMPLX_MUL_SAT_EN
   // Bits above the output sign must all match the sign to be representable
   logic [EW-OUT_W:0] hi;
   assign hi = shifted[EW-1:OUT_W-1];

   always_comb begin
      ovf_c_o  = 1'b0;
      data_c_o = OUT_W'(shifted);
      if (!((&hi) || (~|hi))) begin
         ovf_c_o  = 1'b1;
         data_c_o = shifted[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   assign data_c_o = OUT_W'(shifted);
   assign ovf_c_o  = 1'b0;
`endif

endmodule

// File: rtl/cmplx_mul_pipe.sv
// Four-stage pipelined complex multiplier, a*b or a*conj(b), with a global
// stall enable. Define CMPLX_MUL_SAT_EN for saturating output reduction.
module cmplx_mul_pipe
   import cmplx_mul_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OUT_W  = OUT_W_DEF,
   parameter int unsigned SHIFT  = SHIFT_DEF
) (
   input logic        clk_i,
   input logic        arst_n_i,
   cmplx_mul_if.slave bus
);

   localparam int unsigned FW = full_w(DATA_W);
   localparam int unsigned PW = 2 * DATA_W;

   logic ce_c;

   logic                     v1_q, conj1_q;
   logic signed [DATA_W-1:0] ai1_q, aq1_q, bi1_q, bq1_q;
   logic                     v2_q, conj2_q;
   logic signed [PW-1:0]     p_ii_d, p_qq_d, p_iq_d, p_qi_d;
   logic signed [PW-1:0]     p_ii_q, p_qq_q, p_iq_q, p_qi_q;
   logic                     v3_q;
   logic signed [FW-1:0]     sum_re_d, sum_im_d;
   logic signed [OUT_W-1:0]  res_re_c, res_im_c;
   logic                     ovf_re_c, ovf_im_c;
   logic                     m_valid_q, ovf_q;
   logic signed [OUT_W-1:0]  data_re_q, data_im_q;

   // Every stage moves together unless a held output is being refused
   assign ce_c          = !m_valid_q || bus.m_ready_i;
   assign bus.s_ready_o = ce_c;

   assign p_ii_d = PW'(ai1_q) * PW'(bi1_q);
   assign p_qq_d = PW'(aq1_q) * PW'(bq1_q);
   assign p_iq_d = PW'(ai1_q) * PW'(bq1_q);
   assign p_qi_d = PW'(aq1_q) * PW'(bi1_q);

   always_comb begin
      sum_re_d = FW'(p_ii_q) - FW'(p_qq_q);
      sum_im_d = FW'(p_iq_q) + FW'(p_qi_q);
      if (conj2_q) begin
         sum_re_d = FW'(p_ii_q) + FW'(p_qq_q);
         sum_im_d = FW'(p_qi_q) - FW'(p_iq_q);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         v1_q      <= 1'b0;
         conj1_q   <= 1'b0;
         ai1_q     <= '0;
         aq1_q     <= '0;
         bi1_q     <= '0;
         bq1_q     <= '0;
         v2_q      <= 1'b0;
         conj2_q   <= 1'b0;
         p_ii_q    <= '0;
         p_qq_q    <= '0;
         p_iq_q    <= '0;
         p_qi_q    <= '0;
         v3_q      <= 1'b0;
         m_valid_q <= 1'b0;
         data_re_q <= '0;
         data_im_q <= '0;
         ovf_q     <= 1'b0;
      end else if (ce_c) begin
         v1_q      <= bus.s_valid_i;
         conj1_q   <= bus.conj_i;
         ai1_q     <= bus.data_a_i_i;
         aq1_q     <= bus.data_a_q_i;
         bi1_q     <= bus.data_b_i_i;
         bq1_q     <= bus.data_b_q_i;
         v2_q      <= v1_q;
         conj2_q   <= conj1_q;
         p_ii_q    <= p_ii_d;
         p_qq_q    <= p_qq_d;
         p_iq_q    <= p_iq_d;
         p_qi_q    <= p_qi_d;
         v3_q      <= v2_q;
         m_valid_q <= v3_q;
         data_re_q <= res_re_c;
         data_im_q <= res_im_c;
         ovf_q     <= v3_q & (ovf_re_c | ovf_im_c);
      end
   end

   cmplx_rnd_sat #(.FW(FW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rnd_re (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .ce_i     (ce_c),
      .sum_i    (sum_re_d),
      .data_c_o (res_re_c),
      .ovf_c_o  (ovf_re_c)
   );

   cmplx_rnd_sat #(.FW(FW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rnd_im (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .ce_i     (ce_c),
      .sum_i    (sum_im_d),
      .data_c_o (res_im_c),
      .ovf_c_o  (ovf_im_c)
   );

   assign bus.m_valid_o = m_valid_q;
   assign bus.data_i_o  = data_re_q;
   assign bus.data_q_o  = data_im_q;
   assign bus.ovf_o     = ovf_q;

endmodule
